// File: rtl/alu_operand_buffer.sv
// alu_operand_buffer: source select + immediate conditioning into an in-order valid/ready buffer.
// Optional ALU_OPERAND_SKID_EN: two-entry skid buffer with registered in_ready (default: single entry).
module alu_operand_buffer #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int IMM_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);
  logic [WIDTH-1:0] w_src, w_data;
  logic             w_push, w_pop;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;
  // Out-of-range selects fall back to source 0
  always_comb begin
    w_src = src_bus[WIDTH-1:0];
    for (int i = 1; i < NUM_SRC; i++) if (sel == SEL_W'(i)) w_src = src_bus[i*WIDTH +: WIDTH];
  end
  assign w_data = (mode == 2'b00) ? w_src :
                  (mode == 2'b01) ? {{(WIDTH-IMM_W){w_src[IMM_W-1]}}, w_src[IMM_W-1:0]} :
                  (mode == 2'b10) ? {{(WIDTH-IMM_W){1'b0}}, w_src[IMM_W-1:0]} :
                                    {w_src[WIDTH-2:0], 1'b0};
  assign w_push    = in_valid && in_ready;
  assign w_pop     = r_out_valid && out_ready;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;
`ifdef ALU_OPERAND_SKID_EN
  logic [WIDTH-1:0] r_sk_data;
  logic [SEL_W-1:0] r_sk_sel;
  logic             r_sk_valid, r_in_ready;
  assign in_ready = r_in_ready;
  // Head refills from the skid entry first; in_ready is precomputed from next occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_sk_valid  <= 1'b0;
      r_sk_data   <= '0;
      r_sk_sel    <= '0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      if (!r_out_valid || w_pop) begin
        if (r_sk_valid) begin
          r_out_data <= r_sk_data;
          r_out_sel  <= r_sk_sel;
          r_sk_valid <= 1'b0;
        end else if (w_push) begin
          r_out_data  <= w_data;
          r_out_sel   <= sel;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_push) begin
        r_sk_data  <= w_data;
        r_sk_sel   <= sel;
        r_sk_valid <= 1'b1;
      end
      r_in_ready <= !(r_out_valid && !w_pop && (r_sk_valid || w_push));
    end
  end
`else
  assign in_ready = !r_out_valid || out_ready;
  // Single entry: a push replaces the head, a lone pop empties it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_push) begin
      r_out_data  <= w_data;
      r_out_sel   <= sel;
      r_out_valid <= 1'b1;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_alu_operand_buffer.sv
// tb_alu_operand_buffer: directed checks of selection, conditioning, handshake, flush and reset.
module tb_alu_operand_buffer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] src_bus;
  logic [1:0]  sel, mode;
  logic        in_valid, flush, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        in_ready3, out_valid3;
  logic [15:0] out_data3;
  logic [1:0]  out_sel3;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  alu_operand_buffer #(.WIDTH(16), .NUM_SRC(4), .SEL_W(2), .IMM_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .src_bus(src_bus), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );
  alu_operand_buffer #(.WIDTH(16), .NUM_SRC(3), .SEL_W(2), .IMM_W(8)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .src_bus(src_bus[47:0]), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready3), .flush(flush), .out_data(out_data3),
    .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_bus = {$urandom, $urandom};
      sel = 2'($urandom);
      mode = 2'($urandom);
      in_valid = 1'($urandom);
      flush = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_sel", 32'(out_sel), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_valid3", 32'(out_valid3), 32'h0);
    reset_n = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    src_bus = {16'hABCD, 16'h8001, 16'h00F0, 16'h1234};
    #1;
    chk("ready_idle", 32'(in_ready), 32'h1);
    sel = 2'd1; mode = 2'b01; tick();
    chk("sext_data", 32'(out_data), 32'hFFF0);
    chk("sext_valid", 32'(out_valid), 32'h1);
    chk("sext_sel", 32'(out_sel), 32'h1);
    sel = 2'd1; mode = 2'b10; tick();
    chk("zext_data", 32'(out_data), 32'h00F0);
    sel = 2'd2; mode = 2'b11; tick();
    chk("shl_data", 32'(out_data), 32'h0002);
    chk("shl_sel", 32'(out_sel), 32'h2);
    sel = 2'd3; mode = 2'b00; tick();
    chk("pass_data", 32'(out_data), 32'hABCD);
    chk("pass_sel", 32'(out_sel), 32'h3);
    chk("oob_data", 32'(out_data3), 32'h1234);
    chk("oob_sel", 32'(out_sel3), 32'h3);
    in_valid = 1'b0; out_ready = 1'b0;
    sel = 2'd0; mode = 2'b11; src_bus = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    chk("hold_valid", 32'(out_valid), 32'h1);
    chk("hold_data", 32'(out_data), 32'hABCD);
    out_ready = 1'b1; tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_data_kept", 32'(out_data), 32'hABCD);
    src_bus = 64'h0;
    mode = 2'b00;
    sel = 2'd0;
`ifdef ALU_OPERAND_SKID_EN
    out_ready = 1'b0;
    in_valid = 1'b1;
    src_bus[15:0] = 16'h0001; tick();
    chk("bp_first", 32'(out_data), 32'h0001);
    src_bus[15:0] = 16'h0002; tick();
    chk("bp_full_ready", 32'(in_ready), 32'h0);
    src_bus[15:0] = 16'h0003; tick();
    chk("bp_held_head", 32'(out_data), 32'h0001);
    chk("bp_held_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1; tick();
    chk("bp_out2", 32'(out_data), 32'h0002);
    chk("bp_ready_back", 32'(in_ready), 32'h1);
    tick();
    chk("bp_out3", 32'(out_data), 32'h0003);
    chk("bp_out3_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0; tick();
    chk("bp_empty", 32'(out_valid), 32'h0);
`else
    out_ready = 1'b1;
    in_valid = 1'b1;
    src_bus[15:0] = 16'h0011; tick();
    chk("stream_1", 32'(out_data), 32'h0011);
    src_bus[15:0] = 16'h0022; tick();
    chk("stream_2", 32'(out_data), 32'h0022);
    src_bus[15:0] = 16'h0033; tick();
    chk("stream_3", 32'(out_data), 32'h0033);
    out_ready = 1'b0; #1;
    chk("follow_lo", 32'(in_ready), 32'h0);
    out_ready = 1'b1; #1;
    chk("follow_hi", 32'(in_ready), 32'h1);
    out_ready = 1'b0;
    src_bus[15:0] = 16'h0044; tick();
    chk("stall_keep", 32'(out_data), 32'h0033);
    chk("stall_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("stream_empty", 32'(out_valid), 32'h0);
`endif
    out_ready = 1'b0;
    in_valid = 1'b1;
    src_bus[15:0] = 16'h0055; tick();
    chk("fl_loaded", 32'(out_valid), 32'h1);
    flush = 1'b1;
    src_bus[15:0] = 16'h0066; tick();
    chk("fl_empty", 32'(out_valid), 32'h0);
    flush = 1'b0; in_valid = 1'b0; tick();
    chk("fl_dropped", 32'(out_valid), 32'h0);
    in_valid = 1'b1;
    sel = 2'd2;
    src_bus[47:32] = 16'h0077; tick();
    chk("rm_loaded", 32'(out_data), 32'h0077);
    in_valid = 1'b0;
    reset_n = 1'b0; tick();
    chk("rm_valid", 32'(out_valid), 32'h0);
    chk("rm_data", 32'(out_data), 32'h0);
    chk("rm_sel", 32'(out_sel), 32'h0);
    chk("rm_in_ready", 32'(in_ready), 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_operand_buffer.md
# alu_operand_buffer

Parametrised successor to the datapath's combinational ALU source-B selector. Selects one of `NUM_SRC` operand sources and applies an immediate-conditioning mode: pass, sign-extend, zero-extend or word-scale. The conditioned operand is registered into a small in-order buffer with valid/ready handshakes on both sides. It sits between the control unit's operand-select stage and the ALU input, so the ALU can stall without the controller re-driving sources.

## Interface
Parameters:
- `WIDTH`, 16, operand width in bits (≥ 4).
- `NUM_SRC`, 4, number of operand sources (2–16).
- `SEL_W`, 2, select width; must satisfy 2^SEL_W ≥ NUM_SRC.
- `IMM_W`, 8, immediate field width used by extend modes (1 ≤ IMM_W < WIDTH).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, **synchronous, active-low**.
- `src_bus`  in  NUM_SRC*WIDTH  flattened sources; source i at bits [i*WIDTH +: WIDTH].
- `sel`  in  SEL_W  source index.
- `mode`  in  2  conditioning: 00 pass, 01 sign-extend low IMM_W, 10 zero-extend low IMM_W, 11 shift left 1.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  buffer can accept.
- `flush`  in  1  synchronous discard of all buffered entries.
- `out_data`  out  WIDTH  conditioned operand at buffer head.
- `out_sel`  out  SEL_W  `sel` captured with the head entry.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  ALU consumes head.

## Operation
- Selection: `sel` < NUM_SRC picks source `sel`; `sel` ≥ NUM_SRC picks source 0.
- Conditioning, applied to the selected value `v` before storage:
  - 00: `v` unchanged.
  - 01: `v[IMM_W-1]` replicated into bits WIDTH-1..IMM_W.
  - 10: bits WIDTH-1..IMM_W cleared.
  - 11: `{v[WIDTH-2:0],1'b0}`; the MSB is discarded and no overflow is flagged.
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- The buffer is strictly in-order. Stored fields are the conditioned data and `sel`.
- `out_data` and `out_sel` are registered. When `out_valid`=0 they hold their last value (0 after reset).
- `flush`=1 for one cycle empties the buffer. It takes priority over push and pop in that cycle, and the request presented in that cycle is dropped.
- Reset takes priority over everything, including `flush`. Asserting reset mid-transfer discards all contents.
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, occupancy 0. `in_ready` per Configuration.
- Sources, `sel` and `mode` are sampled only on the push edge. Later changes do not affect stored entries.

## Timing
- Latency: push at edge N gives `out_valid`=1 and the data on `out_data` after edge N.
- Throughput: one push and one pop per cycle in steady state.
- Push and pop in the same cycle leave the occupancy unchanged. The new entry becomes head only if it was the sole remaining entry.
- Empty with push and no pop: occupancy becomes 1.
- A pop from an empty buffer cannot occur because `out_valid`=0.
- `out_ready` may toggle freely while `out_valid`=0.
- Once asserted, `out_valid` and `out_data` stay stable until a pop, flush or reset.

## Configuration
- Macro: `ALU_OPERAND_SKID_EN`.
- Defined: buffer depth is 2.
  - `in_ready` is registered: it is 1 when occupancy < 2, and 1 after reset.
  - `in_ready` has no combinational path from `out_ready`.
  - Full throughput is sustained when `out_ready` is deasserted for isolated cycles.
- Undefined: buffer depth is 1.
  - `in_ready = !out_valid || out_ready` (combinational).
  - `in_ready` is 1 after reset.
  - Push and pop in the same cycle replace the head.

## Test plan
- Reset with `reset_n`=0 for 2 cycles, all inputs random → `out_valid`=0, `out_data`=0x0000, `out_sel`=0, `in_ready`=1.
- Source and mode check, WIDTH=16, IMM_W=8, sources {0x1234, 0x00F0, 0x8001, 0xABCD}, `out_ready`=1:
  - sel=1, mode 01 → 0xFFF0.
  - sel=1, mode 10 → 0x00F0.
  - sel=2, mode 11 → 0x0002.
  - sel=3, mode 00 → 0xABCD.
  - Each result appears one cycle after its push.
- NUM_SRC=3, sel=3, mode 00 → `out_data` equals source 0 and `out_sel`=3.
- Backpressure with the skid buffer compiled in: push 0x0001, 0x0002, 0x0003 back-to-back with `out_ready`=0 → `in_ready` goes 0 after the second push and the third is held off. Then set `out_ready`=1 → outputs 0x0001, 0x0002, 0x0003 in order with no loss or duplication.
- Without `ALU_OPERAND_SKID_EN`, continuous push with `out_ready`=1 → one output per cycle, and `in_ready` follows `out_ready` while full.
- Flush: with 1–2 entries held, assert `flush` together with `in_valid` → `out_valid`=0 next cycle and the concurrent request is not delivered. Next, assert `reset_n`=0 while `out_valid`=1 → buffer empty and outputs return to their reset values.
